mem_arbiter: RTL and testbench

Two-port arbiter and sequencer for the multicycle core's single-port unified instruction/data RAM. It shares the RAM between the core (fetch, load and store traffic) and a host/loader port used for program load, result inspection and debug. Each request completes through a req/ack handshake with round-robin tie-breaking. A host-controlled hold starves the core while the host owns memory, and a core stall-cycle counter feeds CPI accounting.

---
 rtl/mem_arbiter.sv | 122 ++++++++++++
 tb/tb_mem_arbiter.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Two-port (core/host) arbiter and three-phase sequencer for a single-port synchronous RAM.
// Round-robin tie-break, host hold blocks new core grants, saturating core stall counter.
module mem_arbiter #(
  parameter int DW    = 32,
  parameter int IDX_W = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             c_req,
  input  logic             c_we,
  input  logic [31:0]      c_addr,
  input  logic [DW-1:0]    c_wdata,
  output logic [DW-1:0]    c_rdata,
  output logic             c_ack,
  input  logic             h_req,
  input  logic             h_we,
  input  logic [31:0]      h_addr,
  input  logic [DW-1:0]    h_wdata,
  output logic [DW-1:0]    h_rdata,
  output logic             h_ack,
  input  logic             h_hold,
  output logic             m_en,
  output logic             m_we,
  output logic [IDX_W-1:0] m_idx,
  output logic [DW-1:0]    m_wdata,
  input  logic [DW-1:0]    m_rdata,
  output logic [31:0]      c_stall_cnt
);
  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_RESP} state_t;

  state_t           r_state, w_next;
  logic             r_last_h, r_own_h, r_we;
  logic             r_m_en, r_m_we;
  logic [IDX_W-1:0] r_m_idx;
  logic [DW-1:0]    r_m_wdata;
  logic             r_c_ack, r_h_ack;
  logic [DW-1:0]    r_c_rdata, r_h_rdata;
  logic [31:0]      r_stall_cnt;

  logic             w_c_elig, w_h_elig, w_grant, w_sel_h, w_we, w_capture;
  logic [IDX_W-1:0] w_idx;
  logic [DW-1:0]    w_wdata;
  logic             w_unused;

  assign w_c_elig = c_req & ~h_hold;
  assign w_h_elig = h_req;

  always_comb begin
    w_next  = r_state;
    w_grant = 1'b0;
    w_sel_h = 1'b0;
    case (r_state)
      S_IDLE: if (w_c_elig | w_h_elig) begin
        w_grant = 1'b1;
        // On a tie the port that did not win the previous grant goes next.
        w_sel_h = w_h_elig & (~w_c_elig | ~r_last_h);
        w_next  = S_ACCESS;
      end
      S_ACCESS: w_next = S_RESP;
      S_RESP:   w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  assign w_we    = w_sel_h ? h_we : c_we;
  assign w_idx   = w_sel_h ? h_addr[IDX_W+1:2] : c_addr[IDX_W+1:2];
  assign w_wdata = w_sel_h ? h_wdata : c_wdata;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_next;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_last_h    <= 1'b1;
      r_own_h     <= 1'b0;
      r_we        <= 1'b0;
      r_m_en      <= 1'b0;
      r_m_we      <= 1'b0;
      r_m_idx     <= '0;
      r_m_wdata   <= '0;
      r_c_ack     <= 1'b0;
      r_h_ack     <= 1'b0;
      r_c_rdata   <= '0;
      r_h_rdata   <= '0;
      r_stall_cnt <= '0;
    end else begin
      if (w_grant) begin
        r_last_h <= w_sel_h;
        r_own_h  <= w_sel_h;
        r_we     <= w_we;
      end
      // RAM strobes live only for the single ACCESS cycle that follows a grant.
      r_m_en    <= w_grant;
      r_m_we    <= w_grant & w_we;
      r_m_idx   <= w_grant ? w_idx : '0;
      r_m_wdata <= w_grant ? w_wdata : '0;
      r_c_ack   <= (r_state == S_ACCESS) & ~r_own_h;
      r_h_ack   <= (r_state == S_ACCESS) & r_own_h;
      if (w_capture & ~r_own_h) r_c_rdata <= m_rdata;
      if (w_capture &  r_own_h) r_h_rdata <= m_rdata;
      if (c_req && !r_c_ack && (r_stall_cnt != 32'hFFFF_FFFF))
        r_stall_cnt <= r_stall_cnt + 32'd1;
    end
  end

  // RAM read data lands in the ack cycle; forward it there, then hold it in the register.
  assign w_capture   = (r_state == S_RESP) & ~r_we;
  assign c_rdata     = (w_capture & ~r_own_h) ? m_rdata : r_c_rdata;
  assign h_rdata     = (w_capture &  r_own_h) ? m_rdata : r_h_rdata;
  assign c_ack       = r_c_ack;
  assign h_ack       = r_h_ack;
  assign m_en        = r_m_en;
  assign m_we        = r_m_we;
  assign m_idx       = r_m_idx;
  assign m_wdata     = r_m_wdata;
  assign c_stall_cnt = r_stall_cnt;

  // Byte-offset and high address bits alias by design.
  assign w_unused = ^{c_addr[31:IDX_W+2], c_addr[1:0], h_addr[31:IDX_W+2], h_addr[1:0]};
endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: synchronous RAM model, transaction-level reference model,
// directed scenarios and a randomized two-port run.
module tb_mem_arbiter;
  localparam int DW    = 32;
  localparam int IDX_W = 10;

  logic             clk = 1'b0, rst = 1'b0;
  logic             c_req = 1'b0, c_we = 1'b0, h_req = 1'b0, h_we = 1'b0, h_hold = 1'b0;
  logic [31:0]      c_addr = '0, h_addr = '0;
  logic [DW-1:0]    c_wdata = '0, h_wdata = '0, c_rdata, h_rdata, m_wdata;
  logic [DW-1:0]    m_rdata = '0;
  logic             c_ack, h_ack, m_en, m_we;
  logic [IDX_W-1:0] m_idx;
  logic [31:0]      c_stall_cnt;

  always #5 clk = ~clk;

  mem_arbiter #(.DW(DW), .IDX_W(IDX_W)) dut (
    .clk(clk), .rst(rst),
    .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata), .c_rdata(c_rdata), .c_ack(c_ack),
    .h_req(h_req), .h_we(h_we), .h_addr(h_addr), .h_wdata(h_wdata), .h_rdata(h_rdata), .h_ack(h_ack),
    .h_hold(h_hold), .m_en(m_en), .m_we(m_we), .m_idx(m_idx), .m_wdata(m_wdata), .m_rdata(m_rdata),
    .c_stall_cnt(c_stall_cnt)
  );

  // Environment RAM: synchronous read, plus a preload port used only while in reset.
  logic [DW-1:0]    ram [1024];
  logic             pre_we = 1'b0;
  logic [IDX_W-1:0] pre_idx = '0;
  logic [DW-1:0]    pre_data = '0;
  always @(posedge clk) begin
    if (pre_we) ram[pre_idx] <= pre_data;
    if (m_en) begin
      if (m_we) ram[m_idx] <= m_wdata;
      m_rdata <= ram[m_idx];
    end
  end

  int checks = 0, errors = 0;

  // Reference model: each grant owns three edges; data effects appear in the ack cycle.
  logic [31:0] ref_mem [1024];
  int          cyc = 0, next_free = 0, p_g = 0;
  bit          p_vld, p_own_h, p_we, last_h;
  logic [9:0]  p_idx;
  logic [31:0] p_wdata, exp_c_rdata, exp_h_rdata, exp_stall;

  function automatic bit exp_m_en();  return p_vld && (cyc == p_g);                 endfunction
  function automatic bit exp_c_ack(); return p_vld && !p_own_h && (cyc == p_g + 1); endfunction
  function automatic bit exp_h_ack(); return p_vld &&  p_own_h && (cyc == p_g + 1); endfunction

  function automatic void mdl_reset();
    p_vld = 0; last_h = 1; next_free = 0;
    exp_c_rdata = '0; exp_h_rdata = '0; exp_stall = '0;
  endfunction

  function automatic void model_edge();
    int e;
    bit ce, he, selh;
    logic [31:0] a;
    e = cyc + 1;
    if (c_req && !exp_c_ack() && exp_stall != 32'hFFFF_FFFF) exp_stall = exp_stall + 1;
    if (p_vld && e == p_g + 1) begin
      if (p_we)         ref_mem[p_idx] = p_wdata;
      else if (p_own_h) exp_h_rdata = ref_mem[p_idx];
      else              exp_c_rdata = ref_mem[p_idx];
    end
    if (p_vld && e == p_g + 2) p_vld = 0;
    ce = c_req && !h_hold;
    he = h_req;
    if (e >= next_free && (ce || he)) begin
      if (ce && he) selh = (last_h == 0);
      else          selh = he;
      a = selh ? h_addr : c_addr;
      p_vld = 1; p_g = e; next_free = e + 3; last_h = selh; p_own_h = selh;
      p_we = selh ? h_we : c_we;
      p_idx = a[11:2];
      p_wdata = selh ? h_wdata : c_wdata;
    end
  endfunction

  task automatic step();
    if (!rst) mdl_reset(); else model_edge();
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  task automatic start_reset();
    c_req = 0; h_req = 0; h_hold = 0; c_we = 0; h_we = 0;
    rst = 0;
    mdl_reset();
    step();
  endtask

  task automatic end_reset();
    step();
    rst = 1;
    cyc = 0;
    mdl_reset();
  endtask

  task automatic ram_load(input int idx, input logic [31:0] d);
    pre_we = 1; pre_idx = idx[9:0]; pre_data = d;
    ref_mem[idx] = d;
    step();
    pre_we = 0;
  endtask

  task automatic test_reset();
    start_reset(); end_reset();
    h_req = 1; h_we = 1; h_addr = 32'h40; h_wdata = $urandom; c_req = 1;
    step();
    rst = 0; mdl_reset();
    #1;
    checks++; if (m_en !== 1'b0) begin errors++; $display("FAIL rst_async_m_en got %0h want 0", m_en); end
    checks++; if (m_we !== 1'b0) begin errors++; $display("FAIL rst_async_m_we got %0h want 0", m_we); end
    step();
    checks++; if (c_ack !== 1'b0 || h_ack !== 1'b0) begin errors++; $display("FAIL rst_ack got %0h/%0h want 0/0", c_ack, h_ack); end
    checks++; if (c_rdata !== '0 || h_rdata !== '0) begin errors++; $display("FAIL rst_rdata got %h/%h want 0/0", c_rdata, h_rdata); end
    checks++; if (m_idx !== '0 || m_wdata !== '0) begin errors++; $display("FAIL rst_m_bus got %h/%h want 0/0", m_idx, m_wdata); end
    checks++; if (c_stall_cnt !== '0) begin errors++; $display("FAIL rst_stall got %0d want 0", c_stall_cnt); end
    c_req = 0; h_req = 0;
    end_reset();
  endtask

  task automatic test_single_read();
    start_reset();
    ram_load(5, 32'hDEAD_BEEF);
    end_reset();
    c_req = 1; c_we = 0; c_addr = 32'h14; c_wdata = $urandom;
    step();
    checks++; if (m_en !== 1'b1 || m_we !== 1'b0 || m_idx !== 10'd5) begin errors++; $display("FAIL rd_access got en=%0h we=%0h idx=%0d want 1/0/5", m_en, m_we, m_idx); end
    checks++; if (c_ack !== 1'b0) begin errors++; $display("FAIL rd_early_ack got %0h want 0", c_ack); end
    step();
    checks++; if (c_ack !== 1'b1) begin errors++; $display("FAIL rd_ack got %0h want 1", c_ack); end
    checks++; if (c_rdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL rd_data got %h want deadbeef", c_rdata); end
    checks++; if (h_ack !== 1'b0) begin errors++; $display("FAIL rd_h_ack got %0h want 0", h_ack); end
    c_req = 0;
    step();
    checks++; if (c_ack !== 1'b0 || m_en !== 1'b0) begin errors++; $display("FAIL rd_after got ack=%0h en=%0h want 0/0", c_ack, m_en); end
    checks++; if (c_rdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL rd_hold got %h want deadbeef", c_rdata); end
  endtask

  task automatic test_host_write_core_read();
    start_reset(); end_reset();
    h_req = 1; h_we = 1; h_addr = 32'h1001_0000; h_wdata = 32'h34;
    step(); step();
    checks++; if (h_ack !== 1'b1 || c_ack !== 1'b0) begin errors++; $display("FAIL hw_ack got h=%0h c=%0h want 1/0", h_ack, c_ack); end
    checks++; if (h_rdata !== '0) begin errors++; $display("FAIL hw_rdata_hold got %h want 0", h_rdata); end
    h_req = 0;
    step();
    checks++; if (ram[0] !== 32'h34) begin errors++; $display("FAIL hw_ram got %h want 34", ram[0]); end
    c_req = 1; c_we = 0; c_addr = 32'h1001_0000;
    step(); step();
    checks++; if (c_ack !== 1'b1 || c_rdata !== 32'h34) begin errors++; $display("FAIL hw_core_rd got ack=%0h data=%h want 1/34", c_ack, c_rdata); end
    c_req = 0;
    step();
  endtask

  task automatic test_contention();
    bit ord[$];
    int first_c, first_h;
    first_c = -1; first_h = -1;
    start_reset(); end_reset();
    c_req = 1; c_we = 0; c_addr = $urandom;
    h_req = 1; h_we = 0; h_addr = $urandom;
    for (int i = 0; i < 12; i++) begin
      step();
      checks++; if (c_ack !== exp_c_ack() || h_ack !== exp_h_ack()) begin errors++; $display("FAIL cont_ack cyc=%0d got %0h/%0h want %0h/%0h", cyc, c_ack, h_ack, exp_c_ack(), exp_h_ack()); end
      checks++; if (c_rdata !== exp_c_rdata || h_rdata !== exp_h_rdata) begin errors++; $display("FAIL cont_rdata cyc=%0d got %h/%h want %h/%h", cyc, c_rdata, h_rdata, exp_c_rdata, exp_h_rdata); end
      if (c_ack) begin ord.push_back(1'b0); if (first_c < 0) first_c = cyc; end
      if (h_ack) begin ord.push_back(1'b1); if (first_h < 0) first_h = cyc; end
      if (exp_c_ack()) c_addr = $urandom;
      if (exp_h_ack()) h_addr = $urandom;
    end
    checks++; if (first_c != 2 || first_h != 5) begin errors++; $display("FAIL cont_first got c=%0d h=%0d want 2/5", first_c, first_h); end
    checks++;
    if (ord.size() < 4) begin errors++; $display("FAIL cont_count got %0d want >=4", ord.size()); end
    else for (int k = 0; k < 4; k++)
      if (ord[k] !== k[0]) begin errors++; $display("FAIL cont_order idx=%0d got %0d want %0d", k, ord[k], k[0]); end
    c_req = 0; h_req = 0;
    step();
  endtask

  task automatic test_hold();
    int nh, nc;
    nh = 0; nc = 0;
    start_reset(); end_reset();
    h_hold = 1; c_req = 1; c_we = 0; c_addr = $urandom;
    h_req = 1; h_we = 0; h_addr = $urandom;
    for (int i = 0; i < 10; i++) begin
      step();
      if (c_ack) nc++;
      if (h_ack) nh++;
      checks++; if (h_rdata !== exp_h_rdata) begin errors++; $display("FAIL hold_hdata cyc=%0d got %h want %h", cyc, h_rdata, exp_h_rdata); end
      if (exp_h_ack()) begin
        if (nh < 2) h_addr = $urandom;
        else        h_req = 0;
      end
    end
    checks++; if (nc != 0 || nh != 2) begin errors++; $display("FAIL hold_acks got c=%0d h=%0d want 0/2", nc, nh); end
    checks++; if (c_stall_cnt !== 32'd10) begin errors++; $display("FAIL hold_stall got %0d want 10", c_stall_cnt); end
    h_hold = 0;
    step();
    checks++; if (m_en !== 1'b1 || c_ack !== 1'b0) begin errors++; $display("FAIL hold_grant got en=%0h ack=%0h want 1/0", m_en, c_ack); end
    step();
    checks++; if (c_ack !== 1'b1 || c_rdata !== exp_c_rdata) begin errors++; $display("FAIL hold_release got ack=%0h data=%h want 1/%h", c_ack, c_rdata, exp_c_rdata); end
    checks++; if (c_stall_cnt !== 32'd12) begin errors++; $display("FAIL hold_stall2 got %0d want 12", c_stall_cnt); end
    c_req = 0;
    step();
  endtask

  task automatic test_saturation();
    start_reset(); end_reset();
    h_hold = 1; c_req = 1; c_we = 0;
    step();
    force dut.r_stall_cnt = 32'hFFFF_FFFE;
    #1;
    release dut.r_stall_cnt;
    exp_stall = 32'hFFFF_FFFE;
    for (int i = 0; i < 5; i++) begin
      step();
      checks++; if (c_stall_cnt !== exp_stall) begin errors++; $display("FAIL sat_step cyc=%0d got %h want %h", cyc, c_stall_cnt, exp_stall); end
    end
    checks++; if (c_stall_cnt !== 32'hFFFF_FFFF) begin errors++; $display("FAIL sat_final got %h want ffffffff", c_stall_cnt); end
  endtask

  task automatic test_reset_mid_access();
    start_reset();
    ram_load(3, 32'h0);
    end_reset();
    c_req = 1; c_we = 1; c_addr = 32'hC; c_wdata = 32'hA5A5_A5A5;
    step();
    checks++; if (m_we !== 1'b1) begin errors++; $display("FAIL mid_pre_we got %0h want 1", m_we); end
    rst = 0; mdl_reset(); c_req = 0; c_we = 0;
    #1;
    checks++; if (m_we !== 1'b0 || m_en !== 1'b0 || m_idx !== '0 || m_wdata !== '0) begin errors++; $display("FAIL mid_async got we=%0h en=%0h idx=%0h wd=%h want all 0", m_we, m_en, m_idx, m_wdata); end
    step();
    checks++; if (ram[3] !== 32'h0) begin errors++; $display("FAIL mid_ram got %h want 0", ram[3]); end
    checks++; if (c_ack !== 1'b0) begin errors++; $display("FAIL mid_ack got %0h want 0", c_ack); end
    end_reset();
    checks++; if (c_ack !== 1'b0) begin errors++; $display("FAIL mid_ack2 got %0h want 0", c_ack); end
    c_req = 1; c_we = 0; c_addr = 32'hC;
    step(); step();
    checks++; if (c_ack !== 1'b1 || c_rdata !== 32'h0) begin errors++; $display("FAIL mid_after got ack=%0h data=%h want 1/0", c_ack, c_rdata); end
    c_req = 0;
    step();
  endtask

  task automatic test_random();
    bit c_busy, h_busy;
    c_busy = 0; h_busy = 0;
    start_reset();
    for (int i = 0; i < 1024; i++) ram_load(i, $urandom);
    end_reset();
    for (int n = 0; n < 600; n++) begin
      // Core driver: hold until ack, occasionally drop early once granted.
      if (c_busy && exp_c_ack()) begin
        c_busy = 0; c_req = 0;
        if ($urandom_range(0, 1) == 1) begin
          c_busy = 1; c_req = 1; c_we = $urandom_range(0, 1) == 1; c_addr = $urandom; c_wdata = $urandom;
        end
      end else if (c_busy && exp_m_en() && !p_own_h && $urandom_range(0, 7) == 0) c_req = 0;
      else if (!c_busy && $urandom_range(0, 3) == 0) begin
        c_busy = 1; c_req = 1; c_we = $urandom_range(0, 1) == 1; c_addr = $urandom; c_wdata = $urandom;
      end
      if (h_busy && exp_h_ack()) begin
        h_busy = 0; h_req = 0;
        if ($urandom_range(0, 1) == 1) begin
          h_busy = 1; h_req = 1; h_we = $urandom_range(0, 1) == 1; h_addr = $urandom; h_wdata = $urandom;
        end
      end else if (h_busy && exp_m_en() && p_own_h && $urandom_range(0, 7) == 0) h_req = 0;
      else if (!h_busy && $urandom_range(0, 3) == 0) begin
        h_busy = 1; h_req = 1; h_we = $urandom_range(0, 1) == 1; h_addr = $urandom; h_wdata = $urandom;
      end
      if ($urandom_range(0, 9) == 0) h_hold = ~h_hold;
      step();
      checks++; if (c_ack !== exp_c_ack() || h_ack !== exp_h_ack()) begin errors++; $display("FAIL rnd_ack cyc=%0d got %0h/%0h want %0h/%0h", cyc, c_ack, h_ack, exp_c_ack(), exp_h_ack()); end
      checks++; if (m_en !== exp_m_en() || m_we !== (exp_m_en() & p_we)) begin errors++; $display("FAIL rnd_m_ctl cyc=%0d got %0h/%0h want %0h/%0h", cyc, m_en, m_we, exp_m_en(), exp_m_en() & p_we); end
      checks++; if (m_idx !== (exp_m_en() ? p_idx : 10'd0) || m_wdata !== (exp_m_en() ? p_wdata : 32'd0)) begin errors++; $display("FAIL rnd_m_bus cyc=%0d got %h/%h want %h/%h", cyc, m_idx, m_wdata, exp_m_en() ? p_idx : 10'd0, exp_m_en() ? p_wdata : 32'd0); end
      checks++; if (c_rdata !== exp_c_rdata || h_rdata !== exp_h_rdata) begin errors++; $display("FAIL rnd_rdata cyc=%0d got %h/%h want %h/%h", cyc, c_rdata, h_rdata, exp_c_rdata, exp_h_rdata); end
      checks++; if (c_stall_cnt !== exp_stall) begin errors++; $display("FAIL rnd_stall cyc=%0d got %0d want %0d", cyc, c_stall_cnt, exp_stall); end
    end
    c_req = 0; h_req = 0; h_hold = 0;
    repeat (3) step();
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_single_read();
    test_host_write_core_read();
    test_contention();
    test_hold();
    test_saturation();
    test_reset_mid_access();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
